// File: rtl/alu_pkg.sv
// Shared ALU control codes, scheduler state encoding and opcode legality.
// Optional MUL support is enabled by defining ALU_SCHEDULER_MUL_EN.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0110;
    localparam logic [3:0] ALU_NOT = 4'b0111;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA,
            ALU_NOT, ALU_AND, ALU_OR, ALU_XOR: ok = 1'b1;
`ifdef ALU_SCHEDULER_MUL_EN
            ALU_MUL: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr, wrapping; purely combinational.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  index
);

    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU among NREQ requesters; accept->rsp_valid is 2 cycles (3 for MUL under ALU_SCHEDULER_MUL_EN).
// Result is held in RESP until rsp_ready; no new request is granted until the response is taken.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_a,
    input  logic [NREQ-1:0][31:0] req_b,
    input  logic [NREQ-1:0][3:0]  req_op,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [3:0]            alu_ctr,
    input  logic [31:0]           alu_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_err,
    output logic                  busy
);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  ptr_nxt;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [31:0]     a_q;
    logic [31:0]     b_q;
    logic [3:0]      op_q;
    logic            op_ok;
    logic            exec_done;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .index (gnt_idx)
    );

    assign req_ready = (state == IDLE) ? gnt : '0;
    assign ptr_nxt   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    assign op_ok     = op_legal(op_q);

    // ALU inputs are quiet outside EXEC; illegal codes never reach the ALU.
    assign alu_a   = (state == EXEC) ? a_q : '0;
    assign alu_b   = (state == EXEC) ? b_q : '0;
    assign alu_ctr = (state == EXEC && op_ok) ? op_q : 4'b0000;

`ifdef ALU_SCHEDULER_MUL_EN
    logic mul_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_wait <= 1'b0;
        end else begin
            mul_wait <= (state == EXEC) && !mul_wait && (op_q == ALU_MUL);
        end
    end

    assign exec_done = (op_q != ALU_MUL) || mul_wait;
`else
    assign exec_done = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        a_q    <= req_a[gnt_idx];
                        b_q    <= req_b[gnt_idx];
                        op_q   <= req_op[gnt_idx];
                        rsp_id <= gnt_idx;
                        rr_ptr <= ptr_nxt;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        rsp_data  <= op_ok ? alu_out : '0;
                        rsp_err   <= !op_ok;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: models the external ALU and checks grants, latency and results against a reference model.
module tb_alu_scheduler;

    localparam int NREQ = 2;
    localparam int IDW  = $clog2(NREQ);
`ifdef ALU_SCHEDULER_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_a;
    logic [NREQ-1:0][31:0] req_b;
    logic [NREQ-1:0][3:0]  req_op;
    logic [31:0]           alu_a;
    logic [31:0]           alu_b;
    logic [3:0]            alu_ctr;
    logic [31:0]           alu_out;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_err;
    logic                  busy;

    int checks   = 0;
    int failures = 0;
    int exp_ptr  = 0;

    logic [31:0] t_a  [NREQ];
    logic [31:0] t_b  [NREQ];
    logic [3:0]  t_op [NREQ];

    alu_scheduler #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctr   (alu_ctr),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a * b;
            4'b0100: return a << b[4:0];
            4'b0101: return a >> b[4:0];
            4'b0110: return $unsigned($signed(a) >>> b[4:0]);
            4'b0111: return ~a;
            4'b1000: return a & b;
            4'b1001: return a | b;
            4'b1010: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    // The shared ALU itself lives in the environment.
    always_comb alu_out = alu_fn(alu_ctr, alu_a, alu_b);

    function automatic bit legal_m(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: return 1'b1;
            4'd2:    return MUL_EN;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_grant(input logic [NREQ-1:0] m, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (m[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return 0;
    endfunction

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ptr = 0;
    endtask

    // One full transaction from the current IDLE negedge back to IDLE; mask must be non-zero.
    task automatic run_txn(input logic [NREQ-1:0] mask, input int hold);
        int              g;
        int              ncyc;
        logic [31:0]     ed;
        logic            ee;
        logic [3:0]      ectr;
        logic [NREQ-1:0] eg;
        g    = model_grant(mask, exp_ptr);
        eg   = '0;
        eg[g] = 1'b1;
        ee   = !legal_m(t_op[g]);
        ed   = ee ? 32'd0 : alu_fn(t_op[g], t_a[g], t_b[g]);
        ectr = ee ? 4'b0000 : t_op[g];
        ncyc = (MUL_EN && t_op[g] == 4'b0010) ? 2 : 1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i]  = t_a[i];
            req_b[i]  = t_b[i];
            req_op[i] = t_op[i];
        end
        req_valid = mask;
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== eg) begin failures++; $display("FAIL grant: req_ready=%b expected %b", req_ready, eg); end
        @(negedge clk);
        req_valid = NREQ'($urandom);
        for (int c = 0; c < ncyc; c++) begin
            #1;
            checks++; if (alu_ctr !== ectr) begin failures++; $display("FAIL exec_ctr: alu_ctr=%b expected %b", alu_ctr, ectr); end
            checks++; if (alu_a !== t_a[g] || alu_b !== t_b[g]) begin failures++; $display("FAIL exec_operands: a=%h b=%h expected a=%h b=%h", alu_a, alu_b, t_a[g], t_b[g]); end
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== '0) begin failures++; $display("FAIL exec_flags: rsp_valid=%b busy=%b req_ready=%b expected 0 1 0", rsp_valid, busy, req_ready); end
            @(negedge clk);
        end
        for (int h = 0; h <= hold; h++) begin
            req_valid = (h < hold) ? '1 : '0;
            if (h == hold) rsp_ready = 1'b1;
            #1;
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rsp_valid: got %b expected 1 (hold cycle %0d)", rsp_valid, h); end
            checks++; if (rsp_data !== ed || rsp_err !== ee) begin failures++; $display("FAIL rsp_data: data=%h err=%b expected data=%h err=%b", rsp_data, rsp_err, ed, ee); end
            checks++; if (rsp_id !== IDW'(g)) begin failures++; $display("FAIL rsp_id: got %0d expected %0d", rsp_id, g); end
            checks++; if (req_ready !== '0 || busy !== 1'b1 || alu_ctr !== 4'b0000) begin failures++; $display("FAIL resp_flags: req_ready=%b busy=%b alu_ctr=%b expected 0 1 0", req_ready, busy, alu_ctr); end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL back_to_idle: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy); end
        exp_ptr = (g + 1) % NREQ;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_flags: busy=%b rsp_valid=%b rsp_err=%b expected 0 0 0", busy, rsp_valid, rsp_err); end
        checks++; if (rsp_data !== 32'd0 || rsp_id !== '0) begin failures++; $display("FAIL reset_rsp: data=%h id=%0d expected 0 0", rsp_data, rsp_id); end
        checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctr !== 4'd0 || req_ready !== '0) begin failures++; $display("FAIL reset_alu: a=%h b=%h ctr=%b ready=%b expected all 0", alu_a, alu_b, alu_ctr, req_ready); end
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_add;
        t_a[0] = 32'd5; t_b[0] = 32'd7; t_op[0] = 4'b0000;
        t_a[1] = $urandom; t_b[1] = $urandom; t_op[1] = 4'b1000;
        run_txn(2'b01, 0);
    endtask

    task automatic test_alternate;
        int g;
        do_reset;
        @(negedge clk);
        req_a[0] = 32'd10;         req_b[0] = 32'd3; req_op[0] = 4'b0001;
        req_a[1] = 32'h8000_0000;  req_b[1] = 32'd4; req_op[1] = 4'b0110;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            #1;
            checks++; if (req_ready !== ((g == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL alt_grant%0d: req_ready=%b expected grant %0d", k, req_ready, g); end
            @(negedge clk);
            #1;
            checks++; if (alu_ctr !== ((g == 1) ? 4'b0110 : 4'b0001)) begin failures++; $display("FAIL alt_ctr%0d: alu_ctr=%b", k, alu_ctr); end
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== ((g == 1) ? 32'hF800_0000 : 32'd7) || rsp_id !== IDW'(g)) begin failures++; $display("FAIL alt_rsp%0d: valid=%b data=%h id=%0d expected 1 %h %0d", k, rsp_valid, rsp_data, rsp_id, (g == 1) ? 32'hF800_0000 : 32'd7, g); end
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        exp_ptr   = 0;
        @(negedge clk);
    endtask

    task automatic test_illegal;
        t_a[1] = $urandom; t_b[1] = $urandom; t_op[1] = 4'b1111;
        run_txn(2'b10, 1);
        t_a[0] = $urandom; t_b[0] = $urandom; t_op[0] = 4'b0011;
        run_txn(2'b01, 0);
    endtask

    task automatic test_mul;
        t_a[0] = 32'd6; t_b[0] = 32'd7; t_op[0] = 4'b0010;
        run_txn(2'b01, 0);
    endtask

    task automatic test_backpressure;
        t_a[1] = $urandom; t_b[1] = $urandom; t_op[1] = 4'b1010;
        run_txn(2'b10, 5);
    endtask

    task automatic test_reset_exec;
        req_a[0] = 32'd1; req_b[0] = 32'd2; req_op[0] = 4'b0000;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstx_in_exec: busy=%b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || alu_a !== 32'd0 || alu_ctr !== 4'd0 || rsp_id !== '0) begin failures++; $display("FAIL rstx_async: busy=%b rsp_valid=%b alu_a=%h ctr=%b id=%0d expected all 0", busy, rsp_valid, alu_a, alu_ctr, rsp_id); end
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstx_no_rsp: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy); end
        end
        @(negedge clk);
        t_a[0] = $urandom; t_b[0] = $urandom; t_op[0] = 4'b0100;
        t_a[1] = $urandom; t_b[1] = $urandom; t_op[1] = 4'b0101;
        run_txn(2'b11, 0);
    endtask

    task automatic test_random;
        logic [NREQ-1:0] m;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                req_valid = '0;
                #1;
                checks++; if (req_ready !== '0) begin failures++; $display("FAIL idle_no_grant: req_ready=%b expected 0", req_ready); end
                @(negedge clk);
            end
            for (int i = 0; i < NREQ; i++) begin
                t_a[i]  = $urandom;
                t_b[i]  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
                t_op[i] = 4'($urandom);
            end
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_txn(m, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_add;
        test_alternate;
        test_illegal;
        test_mul;
        test_backpressure;
        test_reset_exec;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter NREQ, default 2, number of requesters sharing the ALU; legal range 2..8.
REQ-002 Parameter IDW, default $clog2(NREQ), width of the requester index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-007 req_a, req_b  input  NREQ x 32  per-requester operands.
REQ-008 req_op  input  NREQ x 4  per-requester ALU control code.
REQ-009 alu_a, alu_b  output  32  operands to the shared ALU.
REQ-010 alu_ctr  output  4  control code to the shared ALU.
REQ-011 alu_out  input  32  combinational ALU result.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 rsp_data  output  32  result value.
REQ-015 rsp_id  output  IDW  index of the requester that owns the result.
REQ-016 rsp_err  output  1  operation code rejected.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states are IDLE, EXEC and RESP.
REQ-019 IDLE: grant is round-robin, searching from pointer rr_ptr upward with wrap; req_ready[g] high combinationally for the granted valid requester only; no grant means no req_ready.
REQ-020 A handshake (req_valid[g] & req_ready[g]) latches a, b, op and g, sets rr_ptr = (g+1) mod NREQ, and moves to EXEC.
REQ-021 EXEC lasts exactly one cycle; alu_a/alu_b/alu_ctr come from the latched registers, and alu_out is captured into rsp_data at the cycle end; next state is RESP.
REQ-022 RESP: rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable until rsp_ready=1; a handshake returns the FSM to IDLE.
REQ-023 Latency: request accepted in cycle N gives rsp_valid in cycle N+2; maximum throughput is one operation per 3 cycles.
REQ-024 Legal codes are 0000, 0001, 0100, 0101, 0110, 0111, 1000, 1001, 1010, plus 0010 when enabled under REQ-031.
REQ-025 An illegal code is still accepted and passes through EXEC, but alu_ctr is forced to 0000; rsp_data=0 and rsp_err=1.
REQ-026 Outside EXEC, alu_a=0, alu_b=0 and alu_ctr=0000 (ALU quiet).
REQ-027 A requester that drops req_valid while not granted loses nothing; rr_ptr advances only on handshake.
REQ-028 Simultaneous requests from all NREQ requesters are served in rotating order, and no requester waits more than NREQ grants.

Reset
REQ-029 rst_n low asynchronously forces: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, and the latched operand/op registers to 0.
REQ-030 Reset in EXEC or RESP discards the in-flight operation with no response; the first grant after release goes to requester 0 if valid.

Configuration
REQ-031 Macro ALU_SCHEDULER_MUL_EN defined: code 0010 (MUL) is legal; EXEC extends to two cycles for MUL only, and alu_out is captured at the end of the second cycle.
REQ-032 Macro ALU_SCHEDULER_MUL_EN undefined: code 0010 is illegal and handled per REQ-025.

Structure
REQ-033 A shared package alu_pkg holds the 4-bit ALU code constants (ADD, SUB, MUL, SLL, SRL, SRA, NOT, AND, OR, XOR) and the state enum.
REQ-034 The round-robin grant logic is one sub-module, rr_arbiter (parameters NREQ; inputs req and ptr; outputs one-hot grant and index).

Verification
REQ-035 Requester 0 sends ADD with a=5, b=7; rsp_ready=1 -> rsp_valid two cycles after accept, rsp_data=12, rsp_id=0, rsp_err=0.
REQ-036 Both requesters hold valid continuously with SUB 10-3 and SRA 0x80000000>>4 -> grants alternate 0,1,0,1; responses are 7 and 0xF8000000.
REQ-037 Op 1111 sent -> rsp_err=1, rsp_data=0, alu_ctr=0000 throughout.
REQ-038 rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_data are stable, req_ready is all zero, busy=1.
REQ-039 MUL 6*7: with ALU_SCHEDULER_MUL_EN, rsp_data=42 at N+3; without it, rsp_err=1 and rsp_data=0.
REQ-040 rst_n asserted during EXEC -> outputs are at reset values immediately, no response is issued, and the next grant goes to requester 0.
